// File: rtl/poly_coeff_store_pkg.sv
// Shared Dilithium parameters for the coefficient path.
//   DIL_N   : coefficients per polynomial
//   DIL_Q   : modulus
//   DIL_ETA : bound on small (secret) coefficients, |c| <= ETA
//   COEFF_W : width of a packed coefficient on the unpack bus
package poly_coeff_store_pkg;

   localparam int unsigned DIL_N   = 256;
   localparam int unsigned DIL_Q   = 8380417;
   localparam int          DIL_ETA = 4;
   localparam int unsigned COEFF_W = 32;

   // True when a signed coefficient lies in [-ETA, ETA].
   function automatic logic in_eta_range(input logic signed [COEFF_W-1:0] c);
      return (c >= -DIL_ETA) && (c <= DIL_ETA);
   endfunction

endpackage

// File: rtl/coeff_mod_q_fix.sv
// Maps a signed coefficient into [0,Q) by adding Q to negative values.
// Purely combinational.
// Ports:
//   coeff   : signed input coefficient
//   reduced : coeff + Q if coeff < 0, else coeff
module coeff_mod_q_fix
   import poly_coeff_store_pkg::*;
#(
   parameter int unsigned Q = DIL_Q
) (
   input  logic signed [COEFF_W-1:0] coeff,
   output logic        [COEFF_W-1:0] reduced
);

   always_comb begin
      reduced = coeff;
      if (coeff[COEFF_W-1]) begin
         reduced = coeff + COEFF_W'(Q);
      end
   end

endmodule

// File: rtl/poly_coeff_store.sv
// Latches one unpacked polynomial and streams its reduced coefficients into
// the coefficient RAM at base_addr, base_addr+1, ... (address wraps).
// Optional feature: define POLY_COEFF_STORE_RANGE_CHECK_EN to enable a sticky
// range-error flag on coefficients outside [-ETA, ETA]; otherwise err is 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : store request, accepted only when idle
//   poly_in    : N signed coefficients, coeff k at [32k+31:32k]
//   base_addr  : RAM start address
//   busy       : high from accepted start until done
//   done       : one-cycle pulse after the final write
//   mem_we, mem_ready, mem_addr, mem_wdata : RAM write handshake
//   err        : sticky range-error flag
module poly_coeff_store
   import poly_coeff_store_pkg::*;
#(
   parameter int unsigned N      = DIL_N,
   parameter int unsigned Q      = DIL_Q,
   parameter int unsigned ADDR_W = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [COEFF_W*N-1:0]   poly_in,
   input  logic [ADDR_W-1:0]      base_addr,
   output logic                   busy,
   output logic                   done,
   output logic                   mem_we,
   input  logic                   mem_ready,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [COEFF_W-1:0]     mem_wdata,
   output logic                   err
);

   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]                  state_q;
   logic [IDX_W-1:0]            idx_q;
   logic [IDX_W-1:0]            idx_inc;
   logic [N-1:0][COEFF_W-1:0]   poly_q;
   logic signed [COEFF_W-1:0]   sel_coeff;
   logic [COEFF_W-1:0]          reduced;
   logic                        accept;
   logic                        xfer;

   assign accept = (state_q == ST_IDLE) && start;
   // mem_we is high throughout WRITE, so a ready cycle there is a transfer.
   assign xfer   = (state_q == ST_WRITE) && mem_ready;
   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);

   // The output register always holds the coefficient about to be written, so
   // the reducer looks one entry ahead: coeff 0 straight off the input bus on
   // accept, otherwise the latched entry after the current index.
   always_comb begin
      idx_inc   = idx_q + IDX_W'(1);
      sel_coeff = poly_q[idx_inc];
      if (state_q == ST_IDLE) begin
         sel_coeff = poly_in[COEFF_W-1:0];
      end
   end

   coeff_mod_q_fix #(
      .Q (Q)
   ) u_reduce (
      .coeff   (sel_coeff),
      .reduced (reduced)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         poly_q    <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  poly_q    <= poly_in;
                  idx_q     <= '0;
                  mem_addr  <= base_addr;
                  mem_wdata <= reduced;
                  mem_we    <= 1'b1;
                  state_q   <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (mem_ready) begin
                  if (idx_q == IDX_W'(N - 1)) begin
                     mem_we  <= 1'b0;
                     state_q <= ST_DONE;
                  end else begin
                     idx_q     <= idx_inc;
                     mem_addr  <= mem_addr + ADDR_W'(1);
                     mem_wdata <= reduced;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

`ifdef POLY_COEFF_STORE_RANGE_CHECK_EN
   logic err_q;

   // Checks the raw (unreduced) coefficient of each transferred word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (xfer && !in_eta_range(poly_q[idx_q])) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/poly_coeff_store.md
POLY_COEFF_STORE -- requirements
Module: poly_coeff_store

Interface
REQ-001 Parameter: N, 256, coefficients per polynomial.
REQ-002 Parameter: Q, 8380417, modulus added to negative coefficients.
REQ-003 Parameter: ADDR_W, 10, coefficient RAM address width.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  request to store the polynomial on poly_in.
REQ-007 Port: poly_in  input  32*N  signed 32-bit coefficients, coeff k at bits [32k+31:32k], as produced by the eta unpack stage.
REQ-008 Port: base_addr  input  ADDR_W  RAM start address of the polynomial.
REQ-009 Port: busy  output  1  high from accepted start until done.
REQ-010 Port: done  output  1  one-cycle pulse after the last coefficient is written.
REQ-011 Port: mem_we  output  1  write request to the coefficient RAM.
REQ-012 Port: mem_ready  input  1  RAM accepts the write this cycle.
REQ-013 Port: mem_addr  output  ADDR_W  write address.
REQ-014 Port: mem_wdata  output  32  reduced coefficient in [0,Q).
REQ-015 Port: err  output  1  sticky range-error flag (see Configuration).

Function
REQ-016 FSM states IDLE, WRITE, DONE; reset state IDLE.
REQ-017 In IDLE, start=1 latches poly_in and base_addr into internal registers, clears index to 0, enters WRITE next cycle.
REQ-018 start outside IDLE is ignored; latched data unaffected.
REQ-019 In WRITE: mem_we=1, mem_addr=base+index (mod 2^ADDR_W, wrap permitted), mem_wdata=reduce(latched coeff[index]); all registered outputs.
REQ-020 reduce(c) = c+Q if c<0, else c, 32-bit result.
REQ-021 Transfer occurs when mem_we&&mem_ready; index increments only on transfer; outputs hold stable while mem_ready=0.
REQ-022 Transfer with index=N-1 moves to DONE; mem_we deasserts the next cycle.
REQ-023 DONE lasts exactly one cycle with done=1, then IDLE; start in DONE is ignored.
REQ-024 busy=1 in WRITE and DONE, 0 in IDLE.
REQ-025 Minimum latency start to done: N+2 cycles with mem_ready held high.

Reset
REQ-026 rst_n low asynchronously forces IDLE; busy, done, mem_we, err=0; mem_addr, mem_wdata, index=0.
REQ-027 Reset mid-WRITE abandons the transfer; no further writes issued; no done pulse.

Configuration
REQ-028 Macro POLY_COEFF_STORE_RANGE_CHECK_EN defined: err sets when a transferred coefficient lies outside [-4,4], stays set until next accepted start clears it.
REQ-029 Macro undefined: err tied 0, no check logic; all other behaviour identical.

Structure
REQ-030 N, Q, ETA=4 and the coefficient width belong in the shared Dilithium parameter package.
REQ-031 The reduce function is a natural sub-module, coeff_mod_q_fix, purely combinational.

Verification
REQ-032 Poly all coeff=+4, base 0, mem_ready=1 -> 256 writes addr 0..255 wdata 4, done at cycle N+2, busy low after.
REQ-033 Coeff k=-4, others 0 -> wdata at addr k = 8380413, others 0.
REQ-034 mem_ready toggled 1/0 every cycle -> still 256 writes, addresses strictly sequential, no duplicates, outputs stable in stalled cycles.
REQ-035 base_addr=1000, ADDR_W=10 -> addresses 1000..1023 then 0..231 (wrap).
REQ-036 Range check enabled, coeff 17 = 5 -> err=1 after that transfer, remains 1, cleared by next start; disabled -> err=0.
REQ-037 rst_n pulsed low at index 100, then start -> fresh 256-write sequence from index 0, exactly one done.
